// File: rtl/mont_pkg.sv
// Shared defaults, derived widths and FSM state type for the Montgomery
// constant loader (mont_const_loader and its word collector).
package mont_pkg;

    // Index width that stays legal when an operand is a single word
    function automatic int idx_bits(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    localparam int WORD_W_DEF = 32;
    localparam int NWORDS_DEF = 32;
    localparam int OPERAND_W  = WORD_W_DEF * NWORDS_DEF;
    localparam int IDX_W      = idx_bits(NWORDS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mont_word_collector.sv
// Full-width operand register written one WORD_W slice at a time by index;
// synchronous active-low clear.
module mont_word_collector
    import mont_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int NWORDS   = NWORDS_DEF,
    parameter int IDX_BITS = IDX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IDX_BITS-1:0]      wr_idx,
    input  logic [WORD_W-1:0]        wr_data,
    output logic [WORD_W*NWORDS-1:0] data
);

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_idx == IDX_BITS'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign data[gi*WORD_W +: WORD_W] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/mont_const_loader.sv
// Captures the word-serial r/t streams and n0p after startTransfer and holds
// them for the exponentiation datapath. Optional n0p self-check: N0P_CHECK_EN.
module mont_const_loader
    import mont_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     startTransfer,
    input  logic [WORD_W-1:0]        n0p,
    input  logic [WORD_W-1:0]        r,
    input  logic [WORD_W-1:0]        t,
    input  logic                     ack,
`ifdef N0P_CHECK_EN
    input  logic [WORD_W-1:0]        n_lo,
    output logic                     err,
`endif
    output logic                     busy,
    output logic                     valid,
    output logic [WORD_W*NWORDS-1:0] r_full,
    output logic [WORD_W*NWORDS-1:0] t_full,
    output logic [WORD_W-1:0]        n0p_q,
    output logic                     overrun
);

    localparam int IX_W = idx_bits(NWORDS);

    state_t            state_reg, state_next;
    logic [IX_W-1:0]   idx_reg, idx_next;
    logic [WORD_W-1:0] n0p_reg, n0p_next;
    logic              overrun_reg, overrun_next;
    logic              capture;
    logic              wr_en;
    logic              last_word;

    assign last_word = (idx_reg == IX_W'(NWORDS - 1));

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        n0p_next     = n0p_reg;
        overrun_next = overrun_reg;
        capture      = 1'b0;
        wr_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (startTransfer) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Stream has no strobe: every LOAD cycle carries a word
                wr_en = 1'b1;
                if (last_word) begin
                    state_next = HOLD;
                end else begin
                    idx_next = idx_reg + IX_W'(1);
                end
            end
            HOLD: begin
                if (ack) begin
                    if (startTransfer) begin
                        capture    = 1'b1;
                        idx_next   = '0;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (startTransfer) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            n0p_next = n0p;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            n0p_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            n0p_reg     <= n0p_next;
            overrun_reg <= overrun_next;
        end
    end

    mont_word_collector #(
        .WORD_W   (WORD_W),
        .NWORDS   (NWORDS),
        .IDX_BITS (IX_W)
    ) u_r_collector (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_reg),
        .wr_data (r),
        .data    (r_full)
    );

    mont_word_collector #(
        .WORD_W   (WORD_W),
        .NWORDS   (NWORDS),
        .IDX_BITS (IX_W)
    ) u_t_collector (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_reg),
        .wr_data (t),
        .data    (t_full)
    );

    assign busy    = (state_reg == LOAD);
    assign valid   = (state_reg == HOLD);
    assign n0p_q   = n0p_reg;
    assign overrun = overrun_reg;

`ifdef N0P_CHECK_EN
    logic [WORD_W-1:0] n_lo_reg;
    logic [WORD_W-1:0] check_sum;
    logic              err_reg;

    // A correct n0p satisfies n0p*n == -1 modulo 2^WORD_W
    assign check_sum = n0p_reg * n_lo_reg + WORD_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lo_reg <= '0;
            err_reg  <= 1'b0;
        end else if (capture) begin
            n_lo_reg <= n_lo;
            err_reg  <= 1'b0;
        end else if ((state_reg == LOAD) && last_word) begin
            err_reg <= |check_sum;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: doc/mont_const_loader.md
Name: mont_const_loader

Overview:
- Downstream stage of the Montgomery-constant generator.
- Captures the word-serial r and t streams and the n0p value that the generator emits after its startTransfer pulse.
- Assembles r and t into full-width operands.
- Presents operands plus n0p to the modular-exponentiation datapath through a valid/ack hold handshake.

Parameters:
- WORD_W, 32, width of one streamed word and of n0p
- NWORDS, 32, words per operand; operand width = WORD_W*NWORDS (1024)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- startTransfer  input  1  one-cycle pulse from generator marking stream start
- n0p  input  WORD_W  Montgomery constant -n^-1 mod 2^WORD_W, stable in the startTransfer cycle
- r  input  WORD_W  r stream word, least-significant word first
- t  input  WORD_W  t stream word, same cycle and index as r
- ack  input  1  consumer has taken the operands
- busy  output  1  high while words are being loaded
- valid  output  1  operands complete and held
- r_full  output  WORD_W*NWORDS  assembled r
- t_full  output  WORD_W*NWORDS  assembled t
- n0p_q  output  WORD_W  captured n0p
- overrun  output  1  sticky: startTransfer arrived while valid and not acked

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; busy=0, valid=0, overrun=0; r_full, t_full and n0p_q cleared to 0; word index cleared to 0. Reset applies in any state and aborts a load in progress.
- Stream timing: startTransfer high in cycle k. Word i (0..NWORDS-1) is present on r and t in cycle k+1+i. There is no per-word strobe.
- IDLE:
  - startTransfer=1: capture n0p into n0p_q, clear index, go to LOAD; busy=1 from the next cycle.
- LOAD:
  - Each cycle: write r into r_full[i*WORD_W +: WORD_W] and t into t_full at the same slice; i++.
  - At i=NWORDS-1 the final word is written, go to HOLD. valid=1 and busy=0 in the cycle after the last word (latency NWORDS+1 cycles from startTransfer to valid).
  - startTransfer during LOAD is ignored. The load continues and overrun is not set.
- HOLD:
  - valid=1; outputs stable.
  - ack=1 with startTransfer=0: go to IDLE, valid=0 next cycle. Operand registers keep their values.
  - ack=1 and startTransfer=1 in the same cycle: ack wins. Capture n0p, go directly to LOAD; the new stream begins next cycle.
  - startTransfer=1 with ack=0: ignored, set overrun=1. overrun clears only on reset.
- ack outside HOLD has no effect.
- Index counter is $clog2(NWORDS) bits wide and does not wrap beyond NWORDS-1.

Optional Feature:
- Macro N0P_CHECK_EN.
- When defined:
  - Adds input port n_lo [WORD_W-1:0], the least-significant word of modulus n, sampled with startTransfer.
  - Adds output err, registered.
  - On entry to HOLD: err = ((n0p_q*n_lo + 1) mod 2^WORD_W != 0). err is cleared on the next startTransfer capture and on reset.
  - valid behaviour is unchanged.
- When undefined: no n_lo or err ports and no multiplier logic.

Decomposition:
- Package mont_pkg holds:
  - WORD_W and NWORDS defaults
  - OPERAND_W = WORD_W*NWORDS
  - IDX_W = $clog2(NWORDS)
  - state enum {IDLE, LOAD, HOLD}
- One sub-module, mont_word_collector: indexed word write into a WORD_W*NWORDS register, with reset clear. It is instantiated twice (r, t); the FSM and index stay in the top.

Test Plan:
- Reset mid-LOAD after word 10 -> next cycle busy=0, valid=0, r_full=0; a later startTransfer loads cleanly.
- startTransfer with n0p=32'h8833_C3D1, r words = i+1, t words = 32'hA000_0000+i -> valid exactly 33 cycles after the pulse; r_full[31:0]=1, r_full[1023:992]=32; t_full[1023:992]=32'hA000_001F; n0p_q=32'h8833_C3D1.
- Hold 20 cycles without ack -> outputs unchanged. ack pulse -> valid=0 next cycle.
- In HOLD: pulse startTransfer with ack=0 -> overrun=1, valid stays 1, data unchanged. Then ack and startTransfer in the same cycle -> new load begins, valid=0 next cycle.
- startTransfer pulse during LOAD at word 5 -> ignored; completion timing unchanged; overrun=0.
- N0P_CHECK_EN: n_lo=32'h0000_0003, n0p=32'h5555_5555 -> err=0. Same n_lo with n0p=32'h5555_5556 -> err=1.
